// File: rtl/iter_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip the dividend's leading zeros via leading_zero_count.
`ifdef DIV_EARLY_OUT_EN
module leading_zero_count #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value_i,
  output logic [5:0]      count_o
);
  // Scan upward so the highest set bit writes last; all-zero input yields 32.
  always_comb begin
    count_o = 6'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (value_i[i]) count_o = 6'(XLEN - 1 - i);
    end
  end
endmodule
`endif

module iter_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            sel_rem_q, sel_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [5:0]      lz;
  logic [XLEN:0]   shifted;
  logic            fits;

`ifdef DIV_EARLY_OUT_EN
  leading_zero_count #(.XLEN(XLEN)) u_lzc (
    .value_i (dvd_q),
    .count_o (lz)
  );
`else
  assign lz = 6'd0;
`endif

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign abs_a     = a_neg ? -dividend : dividend;
  assign abs_b     = b_neg ? -divisor : divisor;

  // Shifted partial remainder can exceed 32 bits only for unsigned divisors near 2^32.
  assign shifted = {rem_q, dvd_q[XLEN-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          sel_rem_d = op[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dvd_d     = abs_a;
          dvs_d     = abs_b;
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            state_d  = S_DONE;
          end else if (is_signed && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1) begin
            result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = S_DONE;
          end else if (dividend == '0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        dvd_d   = dvd_q << lz;
        cnt_d   = 6'(XLEN) - lz;
        rem_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        // Quotient bits fill the dividend register as its bits shift out the top.
        rem_d = fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], fits};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_FIX;
      end
      S_FIX: begin
        if (sel_rem_q) result_d = rneg_q ? -rem_q : rem_q;
        else           result_d = qneg_q ? -dvd_q : dvd_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table, random model vectors, corner sequences.
module tb_iter_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  iter_divider #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa;
    int z;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (a == 0) return 1;
    aa = (!o[0] && a[31]) ? -a : a;
    z = 0;
    while (z < 32 && !aa[31 - z]) z++;
`ifdef DIV_EARLY_OUT_EN
    return 32 - z + 3;
`else
    return 35;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Launches one operation, waits for done, and checks value, latency and pulse width.
  task automatic run_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string nm);
    int lat, cyc;
    bit seen;
    logic [31:0] want;
    lat = exp_lat(o, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) seen = 1;
    end
    want = exp_q.pop_front();
    if (!seen) begin
      chk({nm, "_timeout"}, 32'(cyc), 32'(lat));
    end else begin
      chk({nm, "_result"}, result, want);
      chk({nm, "_latency"}, 32'(cyc), 32'(lat));
      @(negedge clk);
      chk({nm, "_pulse"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [31:0] prev, ra, rb;
    logic [1:0] ro;

    tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
    tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
    tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"};
    tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"};
    tbl[4]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_by0"};
    tbl[5]  = '{2'b11, 32'd5,          32'd0,          32'd5,          "remu_by0"};
    tbl[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"};
    tbl[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          "rem_ovf"};
    tbl[8]  = '{2'b00, 32'd0,          32'd5,          32'd0,          "div_zero_a"};
    tbl[9]  = '{2'b11, 32'd1,          32'd1,          32'd0,          "remu_1_1"};
    tbl[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  "div_7_m2"};
    tbl[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          "rem_7_m2"};
    tbl[12] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  "div_by0"};
    tbl[13] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  "rem_by0"};
    tbl[14] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "divu_big"};
    tbl[15] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "remu_big"};
    tbl[16] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  "div_min_1"};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd3;
      run_vec(ro, ra, rb, model(ro, ra, rb), "rand");
    end

    // Second start while busy must be ignored.
    @(negedge clk);
    op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd1; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 10) begin
        op = 2'b01; dividend = 32'd6; divisor = 32'd3; start = 1'b1;
      end
      if (done) seen = 1;
    end
    chk("ignore_start_latency", 32'(cyc), 32'd35);
    chk("ignore_start_result", result, 32'hFFFF_FFFF);

    // Flush mid-division: no done, result held, then a fresh launch.
    prev = result;
    @(negedge clk);
    @(negedge clk);
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    cyc = 0; seen = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      flush = (cyc == 5);
      if (done) seen = 1;
    end
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_result_held", result, prev);
    run_vec(2'b01, 32'd9, 32'd3, 32'd3, "after_flush");

    // Asynchronous reset mid-ITER clears outputs without a clock edge.
    @(negedge clk);
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(2'b11, 32'd17, 32'd5, 32'd2, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
